// File: rtl/reg_wb_ctrl_pkg.sv
// reg_wb_ctrl_pkg: shared widths and types for the register writeback controller
package reg_wb_ctrl_pkg;
    localparam int REG_W    = 3;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 8;
    localparam int CNT_MAX  = 3;
    localparam int CNT_W    = 2;
    localparam int WB_W     = REG_W + DATA_W;
    typedef logic [REG_W-1:0]  reg_idx_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CNT_W-1:0]  cnt_t;
    typedef struct packed {
        reg_idx_t rd;
        data_t    data;
    } wb_req_t;
endpackage

// File: rtl/reg_wb_ctrl_wb_fifo.sv
// wb_fifo: power-of-two FIFO holding load writeback requests; push and pop may coincide when full
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 35
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic         full,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;
    assign empty   = wr_ptr == rd_ptr;
    assign full    = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/reg_wb_ctrl.sv
// reg_wb_ctrl: arbitrates ALU and queued load writebacks onto one register-file port with per-register scoreboarding
module reg_wb_ctrl
    import reg_wb_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_valid,
    input  logic [REG_W-1:0]  alloc_reg,
    output logic              alloc_ready,
    input  logic              alu_valid,
    input  logic [REG_W-1:0]  alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              ld_valid,
    input  logic [REG_W-1:0]  ld_reg,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic [DATA_W-1:0] rf_in,
    output logic [REG_W-1:0]  rf_w,
    output logic              rf_we,
    output logic [NUM_REGS-1:0] busy
);
    cnt_t [NUM_REGS-1:0] cnt;
    cnt_t [NUM_REGS-1:0] cnt_nxt;
    wb_req_t  head;
    wb_req_t  ld_req;
    logic     full;
    logic     empty;
    logic     alloc_fire;
    logic     alu_fire;
    logic     ld_fire;
    logic     pop;
    logic     wr_sel;
    reg_idx_t wr_reg;
    data_t    wr_data;
    assign alloc_ready = !rst && cnt[alloc_reg] != CNT_W'(CNT_MAX);
    assign alu_ready   = !rst && !full;
    assign ld_ready    = !rst && !full;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign alu_fire    = alu_valid && alu_ready;
    assign ld_fire     = ld_valid && ld_ready;
    assign pop         = !rst && !alu_fire && !empty;
    assign wr_sel      = alu_fire || pop;
    assign wr_reg      = alu_fire ? alu_reg : head.rd;
    assign wr_data     = alu_fire ? alu_data : head.data;
    assign ld_req      = '{rd: ld_reg, data: ld_data};
    wb_fifo #(.DEPTH(DEPTH), .W(WB_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ld_fire),
        .din   (ld_req),
        .full  (full),
        .pop   (pop),
        .dout  (head),
        .empty (empty)
    );
    // Decrement saturates at zero so a stray write cannot underflow the count
    always_comb begin
        cnt_nxt = cnt;
        for (int n = 0; n < NUM_REGS; n++) begin
            cnt_nxt[n] = cnt[n]
                + CNT_W'(alloc_fire && alloc_reg == REG_W'(n))
                - CNT_W'(wr_sel && wr_reg == REG_W'(n) && cnt[n] != '0);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            busy  <= '0;
            rf_we <= 1'b0;
            rf_w  <= '0;
            rf_in <= '0;
        end else begin
            cnt   <= cnt_nxt;
            rf_we <= wr_sel;
            rf_w  <= wr_reg;
            rf_in <= wr_data;
            for (int n = 0; n < NUM_REGS; n++)
                busy[n] <= cnt_nxt[n] != '0;
        end
    end
endmodule
